// File: rtl/dcm_gov_pkg.sv
// Shared types and arithmetic helpers for the DCM frequency governor.
// Multiplier math is done at 9 bits so sums and clamps never wrap.
package dcm_gov_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    DWELL
  } gov_state_t;

  typedef logic [7:0] mult_t;
  typedef logic [8:0] wide_t;

  function automatic mult_t clamp_mult(input wide_t v, input wide_t lo, input wide_t hi);
    wide_t r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[7:0];
  endfunction

  // Upward moves are limited to one step; downward moves and the first
  // program after an unknown state (cur == 0) go straight to the target.
  function automatic mult_t step_toward(input mult_t cur, input mult_t eff, input wide_t step);
    wide_t up;
    up = {1'b0, cur} + step;
    if (cur == 8'd0)
      return eff;
    else if (eff > cur)
      return ({1'b0, eff} < up) ? eff : up[7:0];
    else
      return eff;
  endfunction

endpackage

// File: rtl/dcm_gov_timer.sv
// Free-running up-counter with synchronous clear and terminal-count flag,
// shared between the ack-timeout and settling-dwell phases.
module dcm_gov_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else
      r_count <= r_count + WIDTH'(1);
  end

  assign o_done = (r_count == i_limit);

endmodule

// File: rtl/dcm_freq_governor.sv
// Arbitrates host, thermal and auto-tune frequency requests and sequences
// them into single-step, acknowledged programming operations for the DCM.
module dcm_freq_governor
  import dcm_gov_pkg::*;
#(
  parameter int MAX_MULT      = 64,
  parameter int MIN_MULT      = 2,
  parameter int INIT_MULT     = 16,
  parameter int THROTTLE_MULT = 8,
  parameter int STEP          = 4,
  parameter int DWELL_CYCLES  = 256,
  parameter int ACK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       host_req,
  input  logic [7:0] host_mult,
  input  logic       tune_up,
  input  logic       tune_down,
  input  logic       therm_alarm,
  output logic       prog_req,
  output logic [7:0] prog_mult,
  input  logic       prog_ack,
  output logic [7:0] cur_mult,
  output logic [7:0] target_mult,
  output logic       busy,
  output logic       throttled,
  output logic       ack_err
);

  localparam wide_t MIN_W  = wide_t'(MIN_MULT);
  localparam wide_t MAX_W  = wide_t'(MAX_MULT);
  localparam wide_t STEP_W = wide_t'(STEP);
  localparam mult_t MIN_M  = mult_t'(MIN_MULT);
  localparam mult_t MAX_M  = mult_t'(MAX_MULT);
  localparam mult_t STEP_M = mult_t'(STEP);
  localparam mult_t INIT_M = mult_t'(INIT_MULT);
  localparam mult_t THR_M  = clamp_mult(wide_t'(THROTTLE_MULT), MIN_W, MAX_W);
  localparam int    TMAX   = (ACK_TIMEOUT > DWELL_CYCLES) ? ACK_TIMEOUT : DWELL_CYCLES;
  localparam int    TW     = $clog2(TMAX + 1);

  gov_state_t r_state;
  mult_t      r_target;
  mult_t      r_cur;
  mult_t      r_prog_mult;
  logic       r_prog_req;
  logic       r_ack_err;
  logic       r_throttled;

  mult_t          w_target_next;
  wide_t          w_tgt_up;
  mult_t          w_eff;
  mult_t          w_next;
  logic           w_timer_clear;
  logic           w_timer_done;
  logic [TW-1:0]  w_timer_limit;

  // Host request has priority; simultaneous tune pulses cancel each other.
  always_comb begin
    w_tgt_up      = {1'b0, r_target} + STEP_W;
    w_target_next = r_target;
    if (host_req)
      w_target_next = clamp_mult({1'b0, host_mult}, MIN_W, MAX_W);
    else if (tune_up && !tune_down)
      w_target_next = (w_tgt_up > MAX_W) ? MAX_M : w_tgt_up[7:0];
    else if (tune_down && !tune_up)
      w_target_next = ({1'b0, r_target} < MIN_W + STEP_W) ? MIN_M : (r_target - STEP_M);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_target    <= INIT_M;
      r_throttled <= 1'b0;
    end else begin
      r_target    <= w_target_next;
      r_throttled <= therm_alarm && (w_eff < r_target);
    end
  end

  assign w_eff  = (therm_alarm && (r_target > THR_M)) ? THR_M : r_target;
  assign w_next = step_toward(r_cur, w_eff, STEP_W);

  assign w_timer_limit = (r_state == WAIT_ACK) ? TW'(ACK_TIMEOUT - 1) : TW'(DWELL_CYCLES - 1);
  assign w_timer_clear = (r_state == IDLE) ||
                         ((r_state == WAIT_ACK) && (prog_ack || w_timer_done)) ||
                         ((r_state == DWELL) && w_timer_done);

  dcm_gov_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_timer_clear),
    .i_limit (w_timer_limit),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cur       <= 8'd0;
      r_prog_mult <= 8'd0;
      r_prog_req  <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_eff != r_cur) begin
            r_prog_mult <= w_next;
            r_prog_req  <= 1'b1;
            r_state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (prog_ack) begin
            r_cur      <= r_prog_mult;
            r_prog_req <= 1'b0;
            r_state    <= DWELL;
          end else if (w_timer_done) begin
            r_ack_err  <= 1'b1;
            r_prog_req <= 1'b0;
            r_state    <= DWELL;
          end
        end
        DWELL: begin
          if (w_timer_done)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prog_req    = r_prog_req;
  assign prog_mult   = r_prog_mult;
  assign cur_mult    = r_cur;
  assign target_mult = r_target;
  assign busy        = (r_state != IDLE);
  assign throttled   = r_throttled;
  assign ack_err     = r_ack_err;

endmodule

// File: tb/tb_dcm_freq_governor.sv
// Scenario bench for dcm_freq_governor: expected programming values are queued
// as stimulus is applied and checked as each prog_req is served.
module tb_dcm_freq_governor;

  localparam int DWELL  = 256;
  localparam int ACK_TO = 4096;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_req = 1'b0;
  logic [7:0] host_mult = 8'd0;
  logic       tune_up = 1'b0;
  logic       tune_down = 1'b0;
  logic       therm_alarm = 1'b0;
  logic       prog_ack = 1'b0;
  logic       prog_req;
  logic [7:0] prog_mult;
  logic [7:0] cur_mult;
  logic [7:0] target_mult;
  logic       busy;
  logic       throttled;
  logic       ack_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ack = -1;
  logic [7:0] exp_q[$];

  dcm_freq_governor #(
    .MAX_MULT(64), .MIN_MULT(2), .INIT_MULT(16), .THROTTLE_MULT(8),
    .STEP(4), .DWELL_CYCLES(DWELL), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host_req(host_req), .host_mult(host_mult),
    .tune_up(tune_up), .tune_down(tune_down), .therm_alarm(therm_alarm),
    .prog_req(prog_req), .prog_mult(prog_mult), .prog_ack(prog_ack),
    .cur_mult(cur_mult), .target_mult(target_mult), .busy(busy),
    .throttled(throttled), .ack_err(ack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_host(input logic [7:0] m);
    host_mult = m;
    host_req  = 1'b1;
    tick();
    host_req  = 1'b0;
  endtask

  task automatic wait_req(input int limit, output bit ok, output logic [7:0] m, output int t);
    ok = 1'b0;
    m  = 8'd0;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      if (prog_req === 1'b1) begin
        ok = 1'b1;
        m  = prog_mult;
        t  = cyc;
        return;
      end
      tick();
    end
  endtask

  // Scoreboard consumer: each queued value must appear as the next request,
  // respect the dwell spacing, and land in cur_mult once acknowledged.
  task automatic drain(input string tag);
    bit ok;
    logic [7:0] m;
    logic [7:0] e;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_req(ACK_TO + DWELL + 50, ok, m, t);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s req_timeout: prog_req never rose, required prog_mult=%0d", tag, e);
        exp_q.delete();
        return;
      end
      n_checks++;
      if (m !== e) begin
        n_fail++;
        $display("FAIL %s prog_mult: got %0d, required %0d", tag, m, e);
      end
      if (last_ack >= 0) begin
        n_checks++;
        if (t - last_ack < DWELL + 1) begin
          n_fail++;
          $display("FAIL %s spacing: %0d cycles after ack, required >= %0d", tag, t - last_ack, DWELL + 1);
        end
      end
      repeat (3) tick();
      n_checks++;
      if (prog_mult !== m || prog_req !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold: prog_req=%0b prog_mult=%0d, required 1/%0d", tag, prog_req, prog_mult, m);
      end
      prog_ack = 1'b1;
      tick();
      prog_ack = 1'b0;
      last_ack = cyc;
      n_checks++;
      if (prog_req !== 1'b0 || cur_mult !== e) begin
        n_fail++;
        $display("FAIL %s after_ack: prog_req=%0b cur_mult=%0d, required 0/%0d", tag, prog_req, cur_mult, e);
      end
      $display("%s: request prog_mult=%0d at cycle %0d, acked at cycle %0d, cur_mult=%0d",
               tag, m, t, cyc, cur_mult);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({prog_req, busy, throttled, ack_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: req/busy/thr/err=%b, required 0000", {prog_req, busy, throttled, ack_err});
    end
    n_checks++;
    if (prog_mult !== 8'd0 || cur_mult !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mults: prog_mult=%0d cur_mult=%0d, required 0/0", prog_mult, cur_mult);
    end
    n_checks++;
    if (target_mult !== 8'd16) begin
      n_fail++;
      $display("FAIL reset_target: got %0d, required 16", target_mult);
    end
    $display("reset: flags and multipliers sampled while reset_n=0");
    reset_n  = 1'b1;
    last_ack = -1;
    exp_q.push_back(8'd16);
    drain("reset_init");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy_dwell: busy=%0b, required 1", busy);
    end
  endtask

  task automatic test_step_up();
    pulse_host(8'd28);
    n_checks++;
    if (target_mult !== 8'd28) begin
      n_fail++;
      $display("FAIL step_target: got %0d, required 28", target_mult);
    end
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd24);
    exp_q.push_back(8'd28);
    drain("step_up");
  endtask

  task automatic test_throttle();
    therm_alarm = 1'b1;
    exp_q.push_back(8'd8);
    drain("throttle");
    n_checks++;
    if (throttled !== 1'b1 || target_mult !== 8'd28) begin
      n_fail++;
      $display("FAIL throttle_flag: throttled=%0b target=%0d, required 1/28", throttled, target_mult);
    end
    therm_alarm = 1'b0;
    tick();
    n_checks++;
    if (throttled !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_clear: throttled=%0b, required 0", throttled);
    end
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd16);
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd24);
    exp_q.push_back(8'd28);
    drain("unthrottle");
  endtask

  task automatic test_clamp();
    logic [7:0] exp_t[7];
    exp_t = '{8'd64, 8'd2, 8'd2, 8'd62, 8'd64, 8'd64, 8'd40};
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: pulse_host(8'd200);
        1: pulse_host(8'd0);
        2: begin tune_down = 1'b1; tick(); tune_down = 1'b0; end
        3: pulse_host(8'd62);
        4: begin tune_up = 1'b1; tick(); tune_up = 1'b0; end
        5: begin tune_up = 1'b1; tune_down = 1'b1; tick(); tune_up = 1'b0; tune_down = 1'b0; end
        default: begin tune_up = 1'b1; pulse_host(8'd40); tune_up = 1'b0; end
      endcase
      n_checks++;
      if (target_mult !== exp_t[k]) begin
        n_fail++;
        $display("FAIL clamp_step%0d: target_mult=%0d, required %0d", k, target_mult, exp_t[k]);
      end
      $display("clamp: step %0d target_mult=%0d", k, target_mult);
    end
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    n_checks++;
    if (cur_mult !== 8'd28 || prog_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_ack: cur=%0d req=%0b busy=%0b, required 28/0/1", cur_mult, prog_req, busy);
    end
    exp_q.push_back(8'd32);
    exp_q.push_back(8'd36);
    exp_q.push_back(8'd40);
    drain("clamp_follow");
  endtask

  task automatic test_timeout();
    bit ok;
    bit stable;
    logic [7:0] m;
    int t;
    int cnt;
    pulse_host(8'd44);
    wait_req(DWELL + 50, ok, m, t);
    n_checks++;
    if (!ok || m !== 8'd44) begin
      n_fail++;
      $display("FAIL timeout_req: seen=%0b prog_mult=%0d, required 1/44", ok, m);
    end
    cnt    = 0;
    stable = 1'b1;
    while (prog_req === 1'b1 && cnt < ACK_TO + 100) begin
      if (prog_mult !== 8'd44) stable = 1'b0;
      cnt++;
      if (cnt == 100) begin host_mult = 8'd50; host_req = 1'b1; end
      else host_req = 1'b0;
      tick();
    end
    host_req = 1'b0;
    last_ack = cyc;
    $display("timeout: prog_req high for %0d cycles, ack_err=%0b cur_mult=%0d", cnt, ack_err, cur_mult);
    n_checks++;
    if (cnt != ACK_TO) begin
      n_fail++;
      $display("FAIL timeout_len: prog_req high %0d cycles, required %0d", cnt, ACK_TO);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL timeout_hold: prog_mult changed during WAIT_ACK, required constant 44");
    end
    n_checks++;
    if (ack_err !== 1'b1 || cur_mult !== 8'd40 || target_mult !== 8'd50) begin
      n_fail++;
      $display("FAIL timeout_state: err=%0b cur=%0d target=%0d, required 1/40/50", ack_err, cur_mult, target_mult);
    end
    exp_q.push_back(8'd44);
    exp_q.push_back(8'd48);
    exp_q.push_back(8'd50);
    drain("retry");
    n_checks++;
    if (ack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_err_sticky: ack_err=%0b, required 1", ack_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] m;
    int t;
    pulse_host(8'd60);
    wait_req(DWELL + 50, ok, m, t);
    n_checks++;
    if (!ok || m !== 8'd54) begin
      n_fail++;
      $display("FAIL midreset_req: seen=%0b prog_mult=%0d, required 1/54", ok, m);
    end
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (prog_req !== 1'b0 || cur_mult !== 8'd0 || busy !== 1'b0 || ack_err !== 1'b0 || target_mult !== 8'd16) begin
      n_fail++;
      $display("FAIL midreset_state: req=%0b cur=%0d busy=%0b err=%0b target=%0d, required 0/0/0/0/16",
               prog_req, cur_mult, busy, ack_err, target_mult);
    end
    $display("midreset: reset applied during WAIT_ACK at cycle %0d", cyc);
    reset_n  = 1'b1;
    last_ack = -1;
    exp_q.push_back(8'd16);
    drain("midreset_init");
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_throttle();
    test_clamp();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
